// File: rtl/msft_dv_ip_clk_div_gen_pkg.sv
// Shared types and helpers for the multi-channel clock divider:
// the lock-state encoding, the minimum legal divisor and the divisor clamp.
package msft_dv_ip_clk_div_pkg;

    typedef enum logic [0:0] {
        S_WAIT = 1'b0,
        S_RUN  = 1'b1
    } lock_state_t;

    localparam int unsigned MIN_DIV = 2;

    // Divisors below MIN_DIV cannot form a high and a low phase, so they are raised.
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        logic [31:0] r;
        if (d < 32'(MIN_DIV)) begin
            r = 32'(MIN_DIV);
        end else begin
            r = d;
        end
        return r;
    endfunction

endpackage

// File: rtl/msft_dv_ip_clk_div_gen_if.sv
// Configuration and output bundle of the clock divider; the slave side is the
// divider itself, the master side is whoever programs it and consumes the enables.
interface msft_dv_ip_clk_div_gen_if #(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = 8,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
);
    logic              cfgWe_i;
    logic [CH_W-1:0]   cfgCh_i;
    logic [DIV_W-1:0]  cfgDiv_i;
    logic              alignReq_i;
    logic              locked_o;
    logic [NUM_CH-1:0] clkEn_o;
    logic [NUM_CH-1:0] clkDiv_o;
    logic [NUM_CH-1:0] cfgPend_o;

    modport master (
        output cfgWe_i, cfgCh_i, cfgDiv_i, alignReq_i,
        input  locked_o, clkEn_o, clkDiv_o, cfgPend_o
    );

    modport slave (
        input  cfgWe_i, cfgCh_i, cfgDiv_i, alignReq_i,
        output locked_o, clkEn_o, clkDiv_o, cfgPend_o
    );
endinterface

// File: rtl/msft_dv_ip_clk_div_gen_ch.sv
// One divider channel: period counter, active and staged divisor, and the
// registered enable pulse / square wave derived from the next counter value.
module msft_dv_ip_clk_div_ch
    import msft_dv_ip_clk_div_pkg::*;
#(
    parameter int               DIV_W   = 8,
    parameter logic [DIV_W-1:0] DEF_DIV = DIV_W'(2)
) (
    input  logic             sysClk_i,
    input  logic             RESETn_i,
    input  logic             run,
    input  logic             align,
    input  logic             we,
    input  logic [DIV_W-1:0] div,
    output logic             en,
    output logic             clk,
    output logic             pend
);

    logic             run_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cur_r;
    logic [DIV_W-1:0] pend_div_r;
    logic             pending_r;
    logic             en_r;
    logic             clk_r;

    logic [DIV_W-1:0] def_clamp_s;
    logic [DIV_W-1:0] div_clamp_s;
    logic [DIV_W-1:0] pend_eff_s;
    logic             wrap_s;
    logic [DIV_W-1:0] cnt_nxt_s;
    logic [DIV_W-1:0] cur_nxt_s;
    logic             pending_nxt_s;
    logic [DIV_W:0]   half_s;
    logic             en_nxt_s;
    logic             clk_nxt_s;

    // Next counter/divisor state; a staged divisor only lands on a period boundary or an align.
    always_comb begin
        def_clamp_s   = DIV_W'(clamp_div(32'(DEF_DIV)));
        div_clamp_s   = DIV_W'(clamp_div(32'(div)));
        pend_eff_s    = we ? div_clamp_s : pend_div_r;
        wrap_s        = run_r && (cnt_r == (cur_r - DIV_W'(1)));
        cnt_nxt_s     = cnt_r;
        cur_nxt_s     = cur_r;
        pending_nxt_s = pending_r;
        if (!run_r) begin
            cnt_nxt_s     = {DIV_W{1'b0}};
            cur_nxt_s     = we ? div_clamp_s : cur_r;
            pending_nxt_s = 1'b0;
        end else if (align || wrap_s) begin
            cnt_nxt_s     = {DIV_W{1'b0}};
            cur_nxt_s     = pend_eff_s;
            pending_nxt_s = 1'b0;
        end else begin
            cnt_nxt_s     = cnt_r + DIV_W'(1);
            pending_nxt_s = pending_r | we;
        end
        half_s    = ({1'b0, cur_nxt_s} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        en_nxt_s  = run && (cnt_nxt_s == {DIV_W{1'b0}});
        clk_nxt_s = run && ({1'b0, cnt_nxt_s} < half_s);
    end

    // Channel state and output registers.
    always_ff @(posedge sysClk_i) begin
        if (!RESETn_i) begin
            run_r      <= 1'b0;
            cnt_r      <= {DIV_W{1'b0}};
            cur_r      <= def_clamp_s;
            pend_div_r <= def_clamp_s;
            pending_r  <= 1'b0;
            en_r       <= 1'b0;
            clk_r      <= 1'b0;
        end else begin
            run_r      <= run;
            cnt_r      <= cnt_nxt_s;
            cur_r      <= cur_nxt_s;
            pend_div_r <= pend_eff_s;
            pending_r  <= pending_nxt_s;
            en_r       <= en_nxt_s;
            clk_r      <= clk_nxt_s;
        end
    end

    assign en   = en_r;
    assign clk  = clk_r;
    assign pend = pending_r;

endmodule

// File: rtl/msft_dv_ip_clk_div_gen.sv
// Multi-channel clock-enable / divided-clock generator: lock sequencing after
// reset, configuration write decode and NUM_CH independent divider channels.
module msft_dv_ip_clk_div_gen
    import msft_dv_ip_clk_div_pkg::*;
#(
    parameter int                      NUM_CH   = 2,
    parameter int                      DIV_W    = 8,
    parameter int                      LOCK_CYC = 16,
    parameter logic [NUM_CH*DIV_W-1:0] DEF_DIV  = {8'd5, 8'd50},
    parameter int                      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      sysClk_i,
    input  logic                      RESETn_i,
    msft_dv_ip_clk_div_gen_if.slave   bus
);

    localparam int LCNT_W = $clog2(LOCK_CYC) + 1;

    lock_state_t       state_r;
    lock_state_t       state_nxt_s;
    logic [LCNT_W-1:0] lock_cnt_r;
    logic [LCNT_W-1:0] lock_cnt_nxt_s;
    logic              locked_r;
    logic              run_nxt_s;
    logic              align_s;
    logic [NUM_CH-1:0] we_s;
    logic [NUM_CH-1:0] en_s;
    logic [NUM_CH-1:0] clk_s;
    logic [NUM_CH-1:0] pend_s;

    // Lock sequencer: count out LOCK_CYC cycles, then run until reset.
    always_comb begin
        state_nxt_s    = state_r;
        lock_cnt_nxt_s = lock_cnt_r;
        case (state_r)
            S_WAIT: begin
                if (lock_cnt_r != {LCNT_W{1'b1}}) begin
                    lock_cnt_nxt_s = lock_cnt_r + LCNT_W'(1);
                end else begin
                    lock_cnt_nxt_s = lock_cnt_r;
                end
                if (lock_cnt_r == LCNT_W'(LOCK_CYC - 1)) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_WAIT;
                end
            end
            S_RUN: begin
                state_nxt_s = S_RUN;
            end
            default: begin
                state_nxt_s = S_WAIT;
            end
        endcase
        run_nxt_s = (state_nxt_s == S_RUN);
        align_s   = bus.alignReq_i && (state_r == S_RUN);
    end

    // Write decode; selects beyond NUM_CH match no channel and are dropped.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            we_s[i] = bus.cfgWe_i && (32'(bus.cfgCh_i) == 32'(i));
        end
    end

    // Lock state registers.
    always_ff @(posedge sysClk_i) begin
        if (!RESETn_i) begin
            state_r    <= S_WAIT;
            lock_cnt_r <= {LCNT_W{1'b0}};
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            lock_cnt_r <= lock_cnt_nxt_s;
            locked_r   <= run_nxt_s;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        msft_dv_ip_clk_div_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV[g*DIV_W +: DIV_W])
        ) u_ch (
            .sysClk_i (sysClk_i),
            .RESETn_i (RESETn_i),
            .run      (run_nxt_s),
            .align    (align_s),
            .we       (we_s[g]),
            .div      (bus.cfgDiv_i),
            .en       (en_s[g]),
            .clk      (clk_s[g]),
            .pend     (pend_s[g])
        );
    end

    assign bus.locked_o  = locked_r;
    assign bus.clkEn_o   = en_s;
    assign bus.clkDiv_o  = clk_s;
    assign bus.cfgPend_o = pend_s;

endmodule

// File: tb/tb_msft_dv_ip_clk_div_gen.sv
// Scoreboard bench for the clock divider: a time-based reference model queues the
// expected outputs for every edge, and a negedge monitor pops and compares them.
module tb_msft_dv_ip_clk_div_gen;

    localparam int NCH  = 3;
    localparam int DW   = 8;
    localparam int LOCK = 16;
    localparam int CHW  = 2;
    localparam logic [NCH*DW-1:0] DEF = {8'd7, 8'd5, 8'd50};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msft_dv_ip_clk_div_gen_if #(.NUM_CH(NCH), .DIV_W(DW), .CH_W(CHW)) ifc();

    msft_dv_ip_clk_div_gen #(
        .NUM_CH(NCH), .DIV_W(DW), .LOCK_CYC(LOCK), .DEF_DIV(DEF), .CH_W(CHW)
    ) dut (
        .sysClk_i (clk),
        .RESETn_i (rst_n),
        .bus      (ifc)
    );

    typedef struct {
        int             e;
        logic           lk;
        logic [NCH-1:0] en;
        logic [NCH-1:0] dv;
        logic [NCH-1:0] pd;
    } exp_t;

    exp_t sb_q[$];
    int   edge_cnt = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model: each channel is described by its active period, staged period
    // and the edge number at which its current period began.
    int m_cur[NCH];
    int m_pend[NCH];
    int m_start[NCH];
    bit m_pending[NCH];
    bit m_run = 1'b0;
    int m_waited = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    function automatic void model_step(input int e, input logic rn, input logic we,
                                       input int ch, input int dv, input logic al);
        exp_t x;
        logic [NCH*DW-1:0] defv;
        defv = DEF;
        if (!rn) begin
            m_run = 1'b0;
            m_waited = 0;
            for (int i = 0; i < NCH; i++) begin
                m_cur[i] = clampd(int'(defv[i*DW +: DW]));
                m_pend[i] = m_cur[i];
                m_pending[i] = 1'b0;
                m_start[i] = e;
            end
        end else if (!m_run) begin
            if (we && ch < NCH) begin
                m_cur[ch] = clampd(dv);
                m_pend[ch] = clampd(dv);
            end
            m_waited++;
            if (m_waited >= LOCK) begin
                m_run = 1'b1;
                for (int i = 0; i < NCH; i++) m_start[i] = e;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                bit hit;
                bit ended;
                hit = we && (ch == i);
                ended = ((e - 1 - m_start[i]) == (m_cur[i] - 1));
                if (hit) m_pend[i] = clampd(dv);
                if (al || ended) begin
                    m_cur[i] = m_pend[i];
                    m_pending[i] = 1'b0;
                    m_start[i] = e;
                end else if (hit) begin
                    m_pending[i] = 1'b1;
                end
            end
        end
        x.e = e;
        x.lk = m_run;
        for (int i = 0; i < NCH; i++) begin
            x.en[i] = m_run && ((e - m_start[i]) == 0);
            x.dv[i] = m_run && ((e - m_start[i]) < (m_cur[i] + 1) / 2);
            x.pd[i] = m_pending[i];
        end
        sb_q.push_back(x);
    endfunction

    task automatic chk(input string nm, input int e, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0h expected=%0h", nm, e, act, expv);
        end
    endtask

    // Monitor: compare every queued expectation once its edge has occurred.
    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].e <= edge_cnt) begin
                x = sb_q.pop_front();
                if (x.e < edge_cnt) begin
                    chk("sb_stale", x.e, 32'(edge_cnt), 32'(x.e));
                end else begin
                    chk("locked_o", x.e, 32'(ifc.locked_o), 32'(x.lk));
                    chk("clkEn_o", x.e, 32'(ifc.clkEn_o), 32'(x.en));
                    chk("clkDiv_o", x.e, 32'(ifc.clkDiv_o), 32'(x.dv));
                    chk("cfgPend_o", x.e, 32'(ifc.cfgPend_o), 32'(x.pd));
                end
            end
        end
    end

    task automatic cyc(input logic rn, input logic we, input int ch, input int dv, input logic al);
        rst_n = rn;
        ifc.cfgWe_i = we;
        ifc.cfgCh_i = CHW'(ch);
        ifc.cfgDiv_i = DW'(dv);
        ifc.alignReq_i = al;
        model_step(edge_cnt + 1, rn, we, ch, dv, al);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    // Idle until the channel's counter (as the model sees it) reaches k.
    task automatic wait_phase(input int ch, input int k, input int limit);
        bit found;
        found = 1'b0;
        for (int n = 0; n < limit && !found; n++) begin
            if (m_run && (edge_cnt - m_start[ch]) == k) found = 1'b1;
            else idle(1);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_phase ch=%0d got=not_reached expected=cnt_%0d", ch, k);
        end
    endtask

    initial begin : stim
        ifc.cfgWe_i = 1'b0;
        ifc.cfgCh_i = '0;
        ifc.cfgDiv_i = '0;
        ifc.alignReq_i = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 0, 0, 1'b0);
        idle(130);
        wait_phase(1, 2, 20);
        cyc(1'b1, 1'b1, 1, 8, 1'b0);
        idle(40);
        cyc(1'b1, 1'b1, 0, 0, 1'b0);
        cyc(1'b1, 1'b1, 0, 1, 1'b0);
        idle(60);
        cyc(1'b1, 1'b1, 3, 9, 1'b0);
        idle(10);
        cyc(1'b1, 1'b1, 0, 50, 1'b0);
        wait_phase(0, 17, 80);
        cyc(1'b1, 1'b1, 0, 10, 1'b1);
        idle(30);
        cyc(1'b1, 1'b1, 0, 30, 1'b0);
        cyc(1'b0, 1'b0, 0, 0, 1'b0);
        idle(4);
        cyc(1'b1, 1'b1, 1, 7, 1'b0);
        idle(40);
        repeat (800) begin
            cyc(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 12)),
                logic'($urandom_range(0, 49) == 0));
        end
        idle(2);
        @(negedge clk);
        #1;
        chk("sb_drained", edge_cnt, 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
